set_assoc_cache_ctrl: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache controller with true-LRU age replacement and a valid/ready memory-side refill and write-back port. It succeeds the fixed 4-way, 128-set, 20-bit-address control unit and its hit/full detection path. It sits between a single requester (CPU/testbench) and a backing memory model. It adds dirty tracking, eviction write-back, stall-tolerant handshakes and miss replay.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_lru_sel.sv | 44 ++++
 rtl/set_assoc_cache_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the set-associative cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESP,
        S_WB,
        S_REFILL,
        S_WAIT
    } state_t;

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int word_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int byte_bits(input int word_w);
        return $clog2(word_w / 8);
    endfunction

    function automatic int tag_bits(input int addr_w, input int sets, input int block_words,
                                    input int word_w);
        return addr_w - idx_bits(sets) - word_bits(block_words) - byte_bits(word_w);
    endfunction

endpackage

// File: rtl/cache_lru_sel.sv
// Per-set replacement logic: victim choice, hit-way encode and true-LRU age update.
module cache_lru_sel #(
    parameter int WAYS = 4,
    localparam int AW = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]         valid,
    input  logic [WAYS-1:0][AW-1:0] age,
    input  logic [WAYS-1:0]         hit,
    output logic [AW-1:0]           victim,
    output logic [AW-1:0]           hit_way,
    output logic [WAYS-1:0][AW-1:0] age_upd
);

    logic [AW-1:0] old_age;
    logic          found;

    always_comb begin
        hit_way = '0;
        victim  = '0;
        found   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit[w]) hit_way = AW'(w);
        end
        old_age = age[hit_way];
        // Prefer the lowest invalid way; only when the set is full does age decide.
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found) begin
                victim = AW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[w] == AW'(WAYS - 1)) victim = AW'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (hit[w])                age_upd[w] = '0;
            else if (age[w] < old_age) age_upd[w] = age[w] + AW'(1);
            else                       age_upd[w] = age[w];
        end
    end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way write-back, write-allocate cache controller with LRU replacement and
// a valid/ready block refill / write-back port; misses replay through LOOKUP.
module set_assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS        = 4,
    parameter int SETS        = 128,
    parameter int BLOCK_WORDS = 8,
    parameter int WORD_W      = 64,
    parameter int ADDR_W      = 20,
    localparam int BLOCK_W    = BLOCK_WORDS * WORD_W
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [WORD_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [WORD_W-1:0]  resp_rdata,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_we,
    output logic [ADDR_W-1:0]  mem_req_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic               mem_resp_valid,
    input  logic [BLOCK_W-1:0] mem_rdata
);

    localparam int IW  = idx_bits(SETS);
    localparam int WOB = word_bits(BLOCK_WORDS);
    localparam int BYB = byte_bits(WORD_W);
    localparam int TW  = tag_bits(ADDR_W, SETS, BLOCK_WORDS, WORD_W);
    localparam int AW  = $clog2(WAYS);

    state_t state, state_nxt;

    logic                we_q, miss_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q, rdata_q;
    logic [AW-1:0]       victim_q;

    logic [WAYS-1:0]         valid_r [SETS];
    logic [WAYS-1:0]         dirty_r [SETS];
    logic [WAYS-1:0][AW-1:0] age_r   [SETS];
    logic [TW-1:0]           tag_r   [SETS][WAYS];
    logic [BLOCK_W-1:0]      data_r  [SETS][WAYS];

    logic [TW-1:0]           tag_f;
    logic [IW-1:0]           idx_f;
    logic [WOB-1:0]          word_f;
    logic [WAYS-1:0]         hit_vec;
    logic                    is_hit;
    logic [AW-1:0]           victim, hit_way;
    logic [WAYS-1:0][AW-1:0] age_upd;
    logic [WORD_W-1:0]       hit_word;
    logic                    unused_bits;

    assign tag_f       = addr_q[ADDR_W-1 -: TW];
    assign idx_f       = addr_q[BYB+WOB +: IW];
    assign word_f      = addr_q[BYB +: WOB];
    assign unused_bits = ^addr_q;

    always_comb begin
        for (int w = 0; w < WAYS; w++)
            hit_vec[w] = valid_r[idx_f][w] && (tag_r[idx_f][w] == tag_f);
    end

    assign is_hit   = |hit_vec;
    assign hit_word = data_r[idx_f][hit_way][word_f*WORD_W +: WORD_W];

    cache_lru_sel #(.WAYS(WAYS)) u_lru (
        .valid   (valid_r[idx_f]),
        .age     (age_r[idx_f]),
        .hit     (hit_vec),
        .victim  (victim),
        .hit_way (hit_way),
        .age_upd (age_upd)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_wdata     = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (is_hit)
                    state_nxt = S_RESP;
                else if (valid_r[idx_f][victim] && dirty_r[idx_f][victim])
                    state_nxt = S_WB;
                else
                    state_nxt = S_REFILL;
            end
            S_WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_r[idx_f][victim_q], idx_f, {(WOB+BYB){1'b0}}};
                mem_wdata     = data_r[idx_f][victim_q];
                if (mem_req_ready) state_nxt = S_REFILL;
            end
            S_REFILL: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_f, idx_f, {(WOB+BYB){1'b0}}};
                if (mem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) state_nxt = S_LOOKUP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = !miss_q;
                resp_rdata = rdata_q;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control bits and per-line metadata; tag and data stay unreset below.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_r[s][w] <= AW'(w);
            end
            we_q     <= 1'b0;
            miss_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            victim_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        miss_q  <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (is_hit) begin
                        age_r[idx_f] <= age_upd;
                        rdata_q      <= we_q ? wdata_q : hit_word;
                        if (we_q) dirty_r[idx_f][hit_way] <= 1'b1;
                    end else begin
                        miss_q   <= 1'b1;
                        victim_q <= victim;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_r[idx_f][victim_q] <= 1'b1;
                        dirty_r[idx_f][victim_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            if (state == S_LOOKUP && is_hit && we_q)
                data_r[idx_f][hit_way][word_f*WORD_W +: WORD_W] <= wdata_q;
            if (state == S_WAIT && mem_resp_valid) begin
                data_r[idx_f][victim_q] <= mem_rdata;
                tag_r[idx_f][victim_q]  <= tag_f;
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Scoreboard bench: stimulus queues expected responses / memory requests,
// a response monitor and a memory model pop and compare them.
module tb_set_assoc_cache_ctrl;

    localparam int ADDR_W  = 20;
    localparam int WORD_W  = 64;
    localparam int BLOCK_W = 512;

    logic               clk = 1'b0;
    logic               rst_b = 1'b0;
    logic               req_valid = 1'b0, req_we = 1'b0;
    logic [ADDR_W-1:0]  req_addr = '0;
    logic [WORD_W-1:0]  req_wdata = '0;
    logic               req_ready, resp_valid, resp_hit;
    logic [WORD_W-1:0]  resp_rdata;
    logic               mem_req_valid, mem_req_we;
    logic               mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic [BLOCK_W-1:0] mem_wdata;
    logic [BLOCK_W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    set_assoc_cache_ctrl #(.WAYS(4), .SETS(128), .BLOCK_WORDS(8), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct { logic [63:0] rdata; logic hit; } resp_t;
    typedef struct { logic we; logic [19:0] addr; logic [511:0] wdata; } memreq_t;

    resp_t          exp_resp[$];
    memreq_t        exp_mem[$];
    logic [511:0]   mem [logic [19:0]];
    int tests = 0, fails = 0;
    int stall = 0, resp_delay = 0, resp_count = 0;

    function automatic logic [63:0] pat(input logic [19:0] a, input int k);
        return {36'h0, a, 8'(k)};
    endfunction

    function automatic logic [511:0] blk(input logic [19:0] a);
        logic [511:0] b;
        if (mem.exists(a)) return mem[a];
        for (int k = 0; k < 8; k++) b[k*64 +: 64] = pat(a, k);
        return b;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout, required event never seen", name);
    endtask

    task automatic exp_refill(input logic [19:0] a);
        memreq_t e;
        e.we = 1'b0; e.addr = a; e.wdata = '0;
        exp_mem.push_back(e);
    endtask

    task automatic exp_wb(input logic [19:0] a, input logic [511:0] d);
        memreq_t e;
        e.we = 1'b1; e.addr = a; e.wdata = d;
        exp_mem.push_back(e);
    endtask

    // Response monitor
    always @(negedge clk) begin
        resp_t e;
        if (resp_valid) begin
            resp_count++;
            if (exp_resp.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got rdata %0h hit %0b, required no response",
                         resp_rdata, resp_hit);
            end else begin
                e = exp_resp.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_hit", resp_hit, e.hit);
            end
        end
    end

    // Memory model: ready after `stall` cycles, refill response after `resp_delay` cycles
    logic         cap_we;
    logic [19:0]  cap_addr;
    logic [511:0] cap_wdata;
    logic         pend = 1'b0;
    int           pend_cnt = 0;
    logic [19:0]  pend_addr;

    always @(negedge clk) begin
        memreq_t e;
        mem_resp_valid = 1'b0;
        if (mem_req_ready) begin
            mem_req_ready = 1'b0;
            if (exp_mem.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_mem_req: got we %0b addr %0h, required none", cap_we, cap_addr);
            end else begin
                e = exp_mem.pop_front();
                check("mem_req_we", cap_we, e.we);
                check("mem_req_addr", cap_addr, e.addr);
                if (e.we) check("mem_wdata", cap_wdata, e.wdata);
            end
            if (cap_we) mem[cap_addr] = cap_wdata;
            else begin
                pend      = 1'b1;
                pend_cnt  = resp_delay;
                pend_addr = cap_addr;
            end
        end else if (pend) begin
            if (pend_cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = blk(pend_addr);
                pend           = 1'b0;
            end else pend_cnt--;
        end else if (mem_req_valid) begin
            if (stall > 0) stall--;
            else begin
                mem_req_ready = 1'b1;
                cap_we        = mem_req_we;
                cap_addr      = mem_req_addr;
                cap_wdata     = mem_wdata;
            end
        end
    end

    // Issue one request; exp_lat > 0 also checks accept-to-response cycles.
    task automatic issue(input logic we, input logic [19:0] a, input logic [63:0] wd,
                         input logic [63:0] er, input logic eh, input int exp_lat);
        resp_t r;
        int n = 0, lat = 1;
        r.rdata = er; r.hit = eh;
        exp_resp.push_back(r);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) fail_now("req_accept");
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        while (!resp_valid && lat < 300) begin @(negedge clk); lat++; end
        if (lat >= 300) fail_now("resp_wait");
        else if (exp_lat > 0) check("resp_latency", lat, exp_lat);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic stall_watch();
        int n = 0;
        logic [19:0] a0;
        logic        w0;
        while (!mem_req_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_now("stall_mem_req");
        a0 = mem_req_addr;
        w0 = mem_req_we;
        check("stall_first_addr", a0, 20'h0A040);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid_held", mem_req_valid, 1'b1);
            check("stall_addr_stable", mem_req_addr, a0);
            check("stall_we_stable", mem_req_we, w0);
            check("stall_req_ready", req_ready, 1'b0);
            if (i == 1) begin req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00078; end
            if (i == 2) begin req_valid = 1'b0; req_we = 1'b0; end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] b0, wbb;
        int n, rc;
        for (int k = 0; k < 8; k++) b0[k*64 +: 64] = pat(20'h00040, k);
        b0[7*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
        mem[20'h00040] = b0;
        wbb = b0;
        wbb[63:0] = 64'h1122_3344_5566_7788;

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_hit", resp_hit, 1'b0);
        check("rst_resp_rdata", resp_rdata, 64'h0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_req_we", mem_req_we, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, 20'h0);
        check("rst_mem_wdata", mem_wdata, 512'h0);
        rst_b = 1'b1;
        @(negedge clk);

        // Cold miss, then hit with 2-cycle latency
        exp_refill(20'h00040);
        issue(1'b0, 20'h00078, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        issue(1'b0, 20'h00078, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2);
        issue(1'b1, 20'h00040, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 1'b1, 2);
        issue(1'b0, 20'h00040, 64'h0, 64'h1122_3344_5566_7788, 1'b1, 2);

        // Fill remaining ways, then dirty eviction of way 0
        exp_refill(20'h02040);
        issue(1'b0, 20'h02040, 64'h0, pat(20'h02040, 0), 1'b0, 0);
        exp_refill(20'h04040);
        issue(1'b0, 20'h04040, 64'h0, pat(20'h04040, 0), 1'b0, 0);
        exp_refill(20'h06040);
        issue(1'b0, 20'h06040, 64'h0, pat(20'h06040, 0), 1'b0, 0);
        exp_wb(20'h00040, wbb);
        exp_refill(20'h08040);
        issue(1'b0, 20'h08040, 64'h0, pat(20'h08040, 0), 1'b0, 0);

        // LRU order from a clean start
        pulse_reset();
        exp_refill(20'h00040);
        issue(1'b0, 20'h00040, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 0);
        exp_refill(20'h02040);
        issue(1'b0, 20'h02040, 64'h0, pat(20'h02040, 0), 1'b0, 0);
        exp_refill(20'h04040);
        issue(1'b0, 20'h04040, 64'h0, pat(20'h04040, 0), 1'b0, 0);
        exp_refill(20'h06040);
        issue(1'b0, 20'h06040, 64'h0, pat(20'h06040, 0), 1'b0, 0);
        issue(1'b0, 20'h00040, 64'h0, 64'h1122_3344_5566_7788, 1'b1, 2);
        exp_refill(20'h08040);
        issue(1'b0, 20'h08040, 64'h0, pat(20'h08040, 0), 1'b0, 0);
        issue(1'b0, 20'h00040, 64'h0, 64'h1122_3344_5566_7788, 1'b1, 2);
        exp_refill(20'h02040);
        issue(1'b0, 20'h02040, 64'h0, pat(20'h02040, 0), 1'b0, 0);

        // Refill stalled 5 cycles; a req_valid pulse meanwhile is ignored
        stall = 5;
        exp_refill(20'h0A040);
        fork
            issue(1'b0, 20'h0A040, 64'h0, pat(20'h0A040, 0), 1'b0, 0);
            stall_watch();
        join

        // Reset while waiting for refill data
        resp_delay = 4;
        exp_refill(20'h0C040);
        req_valid = 1'b1; req_addr = 20'h0C040;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 50) begin @(negedge clk); n++; end
        while (mem_req_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_now("wait_state_entry");
        rst_b = 1'b0;
        @(negedge clk);
        check("wait_rst_req_ready", req_ready, 1'b1);
        check("wait_rst_mem_req_valid", mem_req_valid, 1'b0);
        check("wait_rst_resp_valid", resp_valid, 1'b0);
        rst_b = 1'b1;
        rc = resp_count;
        repeat (10) @(negedge clk);
        check("no_resp_after_reset", resp_count, rc);
        check("idle_after_late_mem_resp", req_ready, 1'b1);
        resp_delay = 0;
        exp_refill(20'h0C040);
        issue(1'b0, 20'h0C040, 64'h0, pat(20'h0C040, 0), 1'b0, 0);
        exp_refill(20'h00040);
        issue(1'b0, 20'h00078, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("resp_queue_drained", exp_resp.size(), 0);
        check("mem_queue_drained", exp_mem.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
